// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired Moore control sequencer for the Datapath_P2 bus CPU
module control_unit #(
    parameter int IR_W    = 32,
    parameter int OPC_W   = 5,
    parameter int ALUOP_W = 4
) (
    input  logic               Clock,
    input  logic               Clear,
    input  logic [IR_W-1:0]    IR,
    input  logic               CON_FF,
    input  logic               Stop,
    output logic               PCout,
    output logic               Zhighout,
    output logic               Zlowout,
    output logic               MDRout,
    output logic               HIout,
    output logic               LOout,
    output logic               InPortout,
    output logic               Cout,
    output logic               BAout,
    output logic               Rout,
    output logic               MARin,
    output logic               Zin,
    output logic               PCin,
    output logic               MDRin,
    output logic               IRin,
    output logic               Yin,
    output logic               HIin,
    output logic               LOin,
    output logic               OutPortin,
    output logic               Rin,
    output logic               CONin,
    output logic               Gra,
    output logic               Grb,
    output logic               Grc,
    output logic               IncPC,
    output logic               Read,
    output logic               Write,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               Run
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(5'b00000);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(5'b00001);
    localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(5'b00010);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5'b00011);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(5'b00100);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5'b00101);
    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(5'b00110);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5'b01100);
    localparam logic [OPC_W-1:0] OP_BR   = OPC_W'(5'b10010);
    localparam logic [OPC_W-1:0] OP_JR   = OPC_W'(5'b10011);
    localparam logic [OPC_W-1:0] OP_IN   = OPC_W'(5'b10101);
    localparam logic [OPC_W-1:0] OP_OUT  = OPC_W'(5'b10110);
    localparam logic [OPC_W-1:0] OP_MFHI = OPC_W'(5'b10111);
    localparam logic [OPC_W-1:0] OP_MFLO = OPC_W'(5'b11000);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(5'b11010);

    localparam logic [ALUOP_W-1:0] ALU_NONE = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4);

    state_t           state;
    state_t           last_step;
    logic [OPC_W-1:0] opcode;
    logic             unused_ir_bits;

    assign opcode         = IR[IR_W-1 -: OPC_W];
    assign unused_ir_bits = ^IR[IR_W-OPC_W-1:0];

    // Final execute step of each opcode; anything unrecognised is a one-step nop
    always_comb begin
        last_step = S_T3;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI: last_step = S_T5;
            OP_LD, OP_ST:                                   last_step = S_T7;
            OP_BR:                                          last_step = S_T6;
            default:                                        last_step = S_T3;
        endcase
    end

    // State sequencing: fetch, execute up to last_step, then T0 or HALT
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state <= S_RST;
        end else begin
            case (state)
                S_RST:  state <= S_T0;
                S_T0:   state <= S_T1;
                S_T1:   state <= S_T2;
                S_T2:   state <= S_T3;
                S_HALT: state <= S_HALT;
                default: begin
                    if (state == last_step)
                        state <= (opcode == OP_HALT || Stop) ? S_HALT : S_T0;
                    else
                        state <= state_t'(state + 4'd1);
                end
            endcase
        end
    end

    // Moore output decode from state and opcode; branch PCin follows CON_FF live
    always_comb begin
        PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
        HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0;
        BAout = 1'b0; Rout = 1'b0;
        MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
        Yin = 1'b0; HIin = 1'b0; LOin = 1'b0; OutPortin = 1'b0; Rin = 1'b0;
        CONin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
        alu_op = ALU_NONE;
        Run = (state != S_RST) && (state != S_HALT);
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    OP_LDI, OP_LD, OP_ST:  begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                    OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (opcode)
                    OP_ADD: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
                    OP_SUB: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = ALU_SUB; end
                    OP_AND: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = ALU_AND; end
                    OP_OR:  begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = ALU_OR;  end
                    OP_ADDI, OP_LDI, OP_LD, OP_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
                    OP_BR:  begin PCout = 1'b1; Yin = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_LD, OP_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
                    OP_BR:        begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (opcode)
                    OP_LD: begin Read = 1'b1; MDRin = 1'b1; end
                    OP_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    OP_BR: begin Zlowout = 1'b1; PCin = CON_FF; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (opcode)
                    OP_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_ST: Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic [31:0] IR = 32'h0;
    logic        CON_FF = 1'b0;
    logic        Stop = 1'b0;
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, Rin, CONin;
    logic Gra, Grb, Grc, IncPC, Read, Write, Run;
    logic [3:0] alu_op;
    logic [31:0] obs;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] M_PCOUT = 32'd1 << 31, M_ZHIGH = 32'd1 << 30, M_ZLOW = 32'd1 << 29;
    localparam logic [31:0] M_MDROUT = 32'd1 << 28, M_HIOUT = 32'd1 << 27, M_LOOUT = 32'd1 << 26;
    localparam logic [31:0] M_INPOUT = 32'd1 << 25, M_COUT = 32'd1 << 24, M_BAOUT = 32'd1 << 23;
    localparam logic [31:0] M_ROUT = 32'd1 << 22, M_MARIN = 32'd1 << 21, M_ZIN = 32'd1 << 20;
    localparam logic [31:0] M_PCIN = 32'd1 << 19, M_MDRIN = 32'd1 << 18, M_IRIN = 32'd1 << 17;
    localparam logic [31:0] M_YIN = 32'd1 << 16, M_HIIN = 32'd1 << 15, M_LOIN = 32'd1 << 14;
    localparam logic [31:0] M_OUTPIN = 32'd1 << 13, M_RIN = 32'd1 << 12, M_CONIN = 32'd1 << 11;
    localparam logic [31:0] M_GRA = 32'd1 << 10, M_GRB = 32'd1 << 9, M_GRC = 32'd1 << 8;
    localparam logic [31:0] M_INCPC = 32'd1 << 7, M_READ = 32'd1 << 6, M_WRITE = 32'd1 << 5;
    localparam logic [31:0] M_RUN = 32'd1;
    localparam logic [31:0] W_T0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN;

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
        .BAout(BAout), .Rout(Rout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
        .OutPortin(OutPortin), .Rin(Rin), .CONin(CONin), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write), .alu_op(alu_op),
        .Run(Run)
    );

    always #5 Clock = ~Clock;

    assign obs = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
                  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, Rin, CONin,
                  Gra, Grb, Grc, IncPC, Read, Write, alu_op, Run};

    function automatic logic [31:0] alu(input int code);
        return 32'(code) << 1;
    endfunction

    // Reference: full step list of one instruction, written from the ISA table
    task automatic build_seq(input logic [4:0] opc, input logic con);
        logic [31:0] eff_a;
        exp_q.delete();
        exp_q.push_back(W_T0);
        exp_q.push_back(M_RUN | M_ZLOW | M_PCIN | M_READ | M_MDRIN);
        exp_q.push_back(M_RUN | M_MDROUT | M_IRIN);
        eff_a = M_RUN | M_GRB | M_BAOUT | M_YIN;
        case (opc)
            5'd3, 5'd4, 5'd5, 5'd6: begin
                exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
                exp_q.push_back(M_RUN | M_GRC | M_ROUT | M_ZIN | alu(int'(opc) - 2));
                exp_q.push_back(M_RUN | M_ZLOW | M_GRA | M_RIN);
            end
            5'd12, 5'd1: begin
                exp_q.push_back(opc == 5'd12 ? (M_RUN | M_GRB | M_ROUT | M_YIN) : eff_a);
                exp_q.push_back(M_RUN | M_COUT | M_ZIN | alu(1));
                exp_q.push_back(M_RUN | M_ZLOW | M_GRA | M_RIN);
            end
            5'd0, 5'd2: begin
                exp_q.push_back(eff_a);
                exp_q.push_back(M_RUN | M_COUT | M_ZIN | alu(1));
                exp_q.push_back(M_RUN | M_ZLOW | M_MARIN);
                if (opc == 5'd0) begin
                    exp_q.push_back(M_RUN | M_READ | M_MDRIN);
                    exp_q.push_back(M_RUN | M_MDROUT | M_GRA | M_RIN);
                end else begin
                    exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_MDRIN);
                    exp_q.push_back(M_RUN | M_WRITE);
                end
            end
            5'd18: begin
                exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_CONIN);
                exp_q.push_back(M_RUN | M_PCOUT | M_YIN);
                exp_q.push_back(M_RUN | M_COUT | M_ZIN | alu(1));
                exp_q.push_back(M_RUN | M_ZLOW | (con ? M_PCIN : 32'd0));
            end
            5'd19: exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_PCIN);
            5'd21: exp_q.push_back(M_RUN | M_INPOUT | M_GRA | M_RIN);
            5'd22: exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_OUTPIN);
            5'd23: exp_q.push_back(M_RUN | M_HIOUT | M_GRA | M_RIN);
            5'd24: exp_q.push_back(M_RUN | M_LOOUT | M_GRA | M_RIN);
            default: exp_q.push_back(M_RUN);
        endcase
    endtask

    // Drives one instruction from T0 (called at a falling edge) and checks each step
    task automatic run_instr(input logic [31:0] ir, input logic con, input logic stop_end, input string name);
        build_seq(ir[31:27], con);
        IR = ir;
        CON_FF = con;
        for (int k = 0; k < exp_q.size(); k++) begin
            tests_run++;
            if (obs !== exp_q[k]) begin
                tests_failed++;
                $display("FAIL %s step T%0d: got %h expected %h", name, k, obs, exp_q[k]);
            end
            Stop = (k == exp_q.size() - 1) ? stop_end : 1'($urandom_range(0, 1));
            @(negedge Clock);
        end
        Stop = 1'b0;
    endtask

    task automatic do_reset();
        Clear = 1'b0;
        @(negedge Clock);
        Clear = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_reset();
        @(negedge Clock);
        tests_run++;
        if (obs !== 32'd0) begin
            tests_failed++; $display("FAIL reset_state: got %h expected 0", obs);
        end
        Clear = 1'b1;
        @(negedge Clock);
        tests_run++;
        if (obs !== W_T0) begin
            tests_failed++; $display("FAIL reset_release: got %h expected %h", obs, W_T0);
        end
    endtask

    task automatic test_mid_reset();
        IR = 32'h18918000;
        repeat (4) @(negedge Clock);
        tests_run++;
        if (obs !== (M_RUN | M_GRC | M_ROUT | M_ZIN | alu(1))) begin
            tests_failed++; $display("FAIL mid_reset_t4: got %h", obs);
        end
        #1 Clear = 1'b0;
        #1;
        tests_run++;
        if (obs !== 32'd0) begin
            tests_failed++; $display("FAIL mid_reset_async: got %h expected 0", obs);
        end
        @(negedge Clock);
        tests_run++;
        if (obs !== 32'd0) begin
            tests_failed++; $display("FAIL mid_reset_hold: got %h expected 0", obs);
        end
        Clear = 1'b1;
        @(negedge Clock);
        tests_run++;
        if (obs !== W_T0) begin
            tests_failed++; $display("FAIL mid_reset_release: got %h expected %h", obs, W_T0);
        end
    endtask

    task automatic check_t0(input string name);
        tests_run++;
        if (obs !== W_T0) begin
            tests_failed++; $display("FAIL %s_return_t0: got %h expected %h", name, obs, W_T0);
        end
    endtask

    task automatic test_add();
        run_instr(32'h18918000, 1'b0, 1'b0, "add");
        check_t0("add");
    endtask

    task automatic test_ld();
        run_instr(32'h00900055, 1'b1, 1'b0, "ld");
        check_t0("ld");
    endtask

    task automatic test_branch();
        run_instr(32'h91000023, 1'b1, 1'b0, "branch_taken");
        check_t0("branch_taken");
        run_instr(32'h91000023, 1'b0, 1'b0, "branch_not_taken");
        check_t0("branch_not_taken");
    endtask

    task automatic test_st();
        run_instr(32'h10900010, 1'b0, 1'b0, "st");
        check_t0("st");
    endtask

    task automatic test_halt();
        run_instr(32'hD0000000, 1'b0, 1'b0, "halt");
        for (int i = 0; i < 20; i++) begin
            tests_run++;
            if (obs !== 32'd0) begin
                tests_failed++; $display("FAIL halt_hold cycle %0d: got %h expected 0", i, obs);
            end
            IR = $urandom;
            CON_FF = 1'($urandom_range(0, 1));
            @(negedge Clock);
        end
        do_reset();
        check_t0("halt_reset");
    endtask

    task automatic test_stop();
        run_instr(32'h60000000 | 32'($urandom_range(0, 32'h07FF_FFFF)), 1'b0, 1'b1, "addi_stop");
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (obs !== 32'd0) begin
                tests_failed++; $display("FAIL stop_halt cycle %0d: got %h expected 0", i, obs);
            end
            @(negedge Clock);
        end
        do_reset();
        check_t0("stop_reset");
    endtask

    task automatic test_back_to_back();
        logic [4:0] opc;
        for (int n = 0; n < 60; n++) begin
            opc = 5'($urandom_range(0, 31));
            if (opc == 5'd26) opc = 5'd25;
            run_instr({opc, 27'($urandom)}, 1'($urandom_range(0, 1)), 1'b0, "random");
        end
        check_t0("random");
    endtask

    initial begin
        test_reset();
        test_add();
        test_mid_reset();
        test_ld();
        test_branch();
        test_st();
        test_halt();
        test_stop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
